// File: rtl/regfile_hilo.sv
// -----------------------------------------------------------------------------
// regfile_hilo
//   Architectural state behind the write-back stage: 32 x 32-bit general
//   purpose registers (r0 hard-wired to zero) plus the HI/LO register pair.
//   Two combinational read ports serve decode; HI/LO are read out to execute.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> a write presented this cycle is forwarded to matching
//                  read ports and to the HI/LO outputs in the same cycle.
//     undefined -> reads always return stored state.
//
// Ports
//   clk            rising-edge clock for all state
//   rst_n          synchronous active-low reset (also forces all outputs to 0)
//   rf_i_wreg      GPR write enable          rf_i_waddr  GPR write address
//   rf_i_wdata     GPR write data
//   rf_i_we_hilo   HI/LO write enable        rf_i_wdata_hi / rf_i_wdata_lo
//   rf_i_re1/2     read port enables         rf_i_raddr1/2 read addresses
//   rf_o_rdata1/2  read port data            rf_o_hi / rf_o_lo HI/LO values
// -----------------------------------------------------------------------------
module regfile_hilo (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rf_i_wreg,
   input  logic [4:0]  rf_i_waddr,
   input  logic [31:0] rf_i_wdata,
   input  logic        rf_i_we_hilo,
   input  logic [31:0] rf_i_wdata_hi,
   input  logic [31:0] rf_i_wdata_lo,
   input  logic        rf_i_re1,
   input  logic [4:0]  rf_i_raddr1,
   input  logic        rf_i_re2,
   input  logic [4:0]  rf_i_raddr2,
   output logic [31:0] rf_o_rdata1,
   output logic [31:0] rf_o_rdata2,
   output logic [31:0] rf_o_hi,
   output logic [31:0] rf_o_lo
);

   // Entry 0 exists only to keep the array index full-range; it is cleared
   // on reset, never written, and masked on every read path.
   logic [31:0] regs_r [0:31];
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   // State update: reset wins over any write presented on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= 32'd0;
         end
         hi_r <= 32'd0;
         lo_r <= 32'd0;
      end else begin
         if (rf_i_wreg && (rf_i_waddr != 5'd0)) begin
            regs_r[rf_i_waddr] <= rf_i_wdata;
         end
         if (rf_i_we_hilo) begin
            hi_r <= rf_i_wdata_hi;
            lo_r <= rf_i_wdata_lo;
         end
      end
   end

   // Read port 1: reset, disable and r0 all force zero before any forwarding.
   always_comb begin
      rf_o_rdata1 = 32'd0;
      if (!rst_n) begin
         rf_o_rdata1 = 32'd0;
      end else if (!rf_i_re1) begin
         rf_o_rdata1 = 32'd0;
      end else if (rf_i_raddr1 == 5'd0) begin
         rf_o_rdata1 = 32'd0;
`ifdef REGFILE_BYPASS_EN
      end else if (rf_i_wreg && (rf_i_waddr == rf_i_raddr1)) begin
         rf_o_rdata1 = rf_i_wdata;
`endif
      end else begin
         rf_o_rdata1 = regs_r[rf_i_raddr1];
      end
   end

   // Read port 2: identical priority chain, independent of port 1.
   always_comb begin
      rf_o_rdata2 = 32'd0;
      if (!rst_n) begin
         rf_o_rdata2 = 32'd0;
      end else if (!rf_i_re2) begin
         rf_o_rdata2 = 32'd0;
      end else if (rf_i_raddr2 == 5'd0) begin
         rf_o_rdata2 = 32'd0;
`ifdef REGFILE_BYPASS_EN
      end else if (rf_i_wreg && (rf_i_waddr == rf_i_raddr2)) begin
         rf_o_rdata2 = rf_i_wdata;
`endif
      end else begin
         rf_o_rdata2 = regs_r[rf_i_raddr2];
      end
   end

   // HI/LO read-out: HI and LO always move together, including when forwarded.
   always_comb begin
      rf_o_hi = 32'd0;
      rf_o_lo = 32'd0;
      if (!rst_n) begin
         rf_o_hi = 32'd0;
         rf_o_lo = 32'd0;
`ifdef REGFILE_BYPASS_EN
      end else if (rf_i_we_hilo) begin
         rf_o_hi = rf_i_wdata_hi;
         rf_o_lo = rf_i_wdata_lo;
`endif
      end else begin
         rf_o_hi = hi_r;
         rf_o_lo = lo_r;
      end
   end

endmodule

// File: tb/tb_regfile_hilo.sv
module tb_regfile_hilo;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        wreg;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        we_hilo;
   logic [31:0] wdata_hi;
   logic [31:0] wdata_lo;
   logic        re1;
   logic [4:0]  raddr1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   // reference state: architectural registers as a plain array
   logic [31:0] m_regs [0:31];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   regfile_hilo dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rf_i_wreg     (wreg),
      .rf_i_waddr    (waddr),
      .rf_i_wdata    (wdata),
      .rf_i_we_hilo  (we_hilo),
      .rf_i_wdata_hi (wdata_hi),
      .rf_i_wdata_lo (wdata_lo),
      .rf_i_re1      (re1),
      .rf_i_raddr1   (raddr1),
      .rf_i_re2      (re2),
      .rf_i_raddr2   (raddr2),
      .rf_o_rdata1   (rdata1),
      .rf_o_rdata2   (rdata2),
      .rf_o_hi       (hi),
      .rf_o_lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        wreg;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        we_hilo;
      logic [31:0] whi;
      logic [31:0] wlo;
      logic        re1;
      logic [4:0]  ra1;
      logic        re2;
      logic [4:0]  ra2;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   vec_t tbl [0:16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic re, input logic [4:0] a);
      if (!rst_n)                           return 32'd0;
      if (!re)                              return 32'd0;
      if (a == 5'd0)                        return 32'd0;
      if (BYP && wreg && (waddr == a))      return wdata;
      return m_regs[a];
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_hi = 32'd0;
         m_lo = 32'd0;
      end else begin
         if (wreg && waddr != 5'd0) m_regs[waddr] = wdata;
         if (we_hilo) begin
            m_hi = wdata_hi;
            m_lo = wdata_lo;
         end
      end
   endtask

   // advance one cycle: outputs have already been checked by the caller
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model(input string tag);
      @(negedge clk);
      check({tag, "_rd1"}, rdata1, model_read(re1, raddr1));
      check({tag, "_rd2"}, rdata2, model_read(re2, raddr2));
      check({tag, "_hi"}, hi, !rst_n ? 32'd0 : (BYP && we_hilo) ? wdata_hi : m_hi);
      check({tag, "_lo"}, lo, !rst_n ? 32'd0 : (BYP && we_hilo) ? wdata_lo : m_lo);
   endtask

   task automatic idle();
      wreg = 1'b0; waddr = 5'd0; wdata = 32'd0;
      we_hilo = 1'b0; wdata_hi = 32'd0; wdata_lo = 32'd0;
      re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
      rst_n = 1'b0;
      idle();

      //          rst   wr    wa     wdata          hl    hi             lo             re1   a1     re2   a2     e1                                e2                                ehi                          elo
      tbl[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'h00000001, 32'h00000002, 1'b1, 5'd5,  1'b1, 5'd5,  32'd0,                            32'd0,                            32'd0,                       32'd0};
      tbl[1]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'h00000001, 32'h00000002, 1'b1, 5'd5,  1'b1, 5'd5,  32'd0,                            32'd0,                            32'd0,                       32'd0};
      tbl[2]  = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,        1'b1, 5'd5,  1'b1, 5'd5,  32'd0,                            32'd0,                            32'd0,                       32'd0};
      tbl[3]  = '{1'b1, 1'b1, 5'd7,  32'h12345678, 1'b0, 32'd0,        32'd0,        1'b1, 5'd7,  1'b1, 5'd7,  BYP ? 32'h12345678 : 32'd0,       BYP ? 32'h12345678 : 32'd0,       32'd0,                       32'd0};
      tbl[4]  = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678,                     32'h12345678,                     32'd0,                       32'd0};
      tbl[5]  = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,        1'b0, 5'd7,  1'b1, 5'd7,  32'd0,                            32'h12345678,                     32'd0,                       32'd0};
      tbl[6]  = '{1'b1, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'd0,        32'd0,        1'b1, 5'd0,  1'b1, 5'd0,  32'd0,                            32'd0,                            32'd0,                       32'd0};
      tbl[7]  = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,        1'b1, 5'd0,  1'b1, 5'd0,  32'd0,                            32'd0,                            32'd0,                       32'd0};
      tbl[8]  = '{1'b1, 1'b1, 5'd9,  32'h00000001, 1'b0, 32'd0,        32'd0,        1'b1, 5'd7,  1'b1, 5'd9,  32'h12345678,                     BYP ? 32'h00000001 : 32'd0,       32'd0,                       32'd0};
      tbl[9]  = '{1'b1, 1'b1, 5'd9,  32'hA5A5A5A5, 1'b0, 32'd0,        32'd0,        1'b1, 5'd9,  1'b1, 5'd9,  BYP ? 32'hA5A5A5A5 : 32'h1,       BYP ? 32'hA5A5A5A5 : 32'h1,       32'd0,                       32'd0};
      tbl[10] = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,        1'b1, 5'd9,  1'b1, 5'd9,  32'hA5A5A5A5,                     32'hA5A5A5A5,                     32'd0,                       32'd0};
      tbl[11] = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b1, 32'h00000002, 32'h80000000, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,                            32'd0,                            BYP ? 32'h2 : 32'd0,         BYP ? 32'h80000000 : 32'd0};
      tbl[12] = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b0, 5'd0,  32'd0,                            32'd0,                            32'h2,                       32'h80000000};
      tbl[13] = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'h0000FFFF, 32'hFFFF0000, 1'b1, 5'd9,  1'b0, 5'd9,  32'hA5A5A5A5,                     32'd0,                            32'h2,                       32'h80000000};
      tbl[14] = '{1'b1, 1'b1, 5'd3,  32'h00000055, 1'b0, 32'd0,        32'd0,        1'b1, 5'd3,  1'b1, 5'd7,  BYP ? 32'h55 : 32'd0,             32'h12345678,                     32'h2,                       32'h80000000};
      tbl[15] = '{1'b0, 1'b1, 5'd4,  32'h00000066, 1'b1, 32'h11111111, 32'h22222222, 1'b1, 5'd3,  1'b1, 5'd4,  32'd0,                            32'd0,                            32'd0,                       32'd0};
      tbl[16] = '{1'b1, 1'b0, 5'd0,  32'd0,        1'b0, 32'd0,        32'd0,        1'b1, 5'd3,  1'b1, 5'd4,  32'd0,                            32'd0,                            32'd0,                       32'd0};

      // directed table: one row per cycle, checked before the edge it writes on
      for (int i = 0; i < 17; i++) begin
         rst_n = tbl[i].rst_n; wreg = tbl[i].wreg; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
         we_hilo = tbl[i].we_hilo; wdata_hi = tbl[i].whi; wdata_lo = tbl[i].wlo;
         re1 = tbl[i].re1; raddr1 = tbl[i].ra1; re2 = tbl[i].re2; raddr2 = tbl[i].ra2;
         @(negedge clk);
         check($sformatf("vec%0d_rd1", i), rdata1, tbl[i].e1);
         check($sformatf("vec%0d_rd2", i), rdata2, tbl[i].e2);
         check($sformatf("vec%0d_hi", i), hi, tbl[i].ehi);
         check($sformatf("vec%0d_lo", i), lo, tbl[i].elo);
         step();
      end

      // hand sequence: back-to-back writes to one register, last one wins
      idle();
      rst_n = 1'b1;
      wreg = 1'b1; waddr = 5'd12; wdata = 32'hCAFE0001;
      step();
      wdata = 32'hCAFE0002;
      step();
      wreg = 1'b0; re1 = 1'b1; raddr1 = 5'd12; re2 = 1'b1; raddr2 = 5'd3;
      @(negedge clk);
      check("b2b_r12", rdata1, 32'hCAFE0002);
      check("b2b_r3_after_reset", rdata2, 32'd0);
      step();

      // randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         rst_n    = ($urandom_range(0, 29) != 0);
         wreg     = $urandom_range(0, 1);
         waddr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         wdata    = $urandom;
         we_hilo  = ($urandom_range(0, 3) == 0);
         wdata_hi = $urandom;
         wdata_lo = $urandom;
         re1      = ($urandom_range(0, 4) != 0);
         raddr1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 7));
         re2      = ($urandom_range(0, 4) != 0);
         raddr2   = ($urandom_range(0, 2) == 0) ? raddr1 : 5'($urandom_range(0, 31));
         check_model("rand");
         step();
      end

      // hand sequence: reset with writes pending, then every register reads 0
      idle();
      rst_n = 1'b0; wreg = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      we_hilo = 1'b1; wdata_hi = 32'h5; wdata_lo = 32'h6;
      check_model("rst_hold");
      step();
      idle();
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         re1 = 1'b1; raddr1 = 5'(a); re2 = 1'b1; raddr2 = 5'(31 - a);
         @(negedge clk);
         check($sformatf("clr_p1_r%0d", a), rdata1, 32'd0);
         check($sformatf("clr_p2_r%0d", 31 - a), rdata2, 32'd0);
         check("clr_hi", hi, 32'd0);
         check("clr_lo", lo, 32'd0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
